// File: rtl/sid_dca_pkg.sv
// Shared types and constants for the SID DCA stage: slot layout, data widths
// and the waveform centring helper used at pipeline stage 1.
package sid;

  localparam int NUM_SLOTS       = 6;
  localparam int VOICES_PER_CHIP = 3;
  localparam int DCA_SLOT_BASE   = 6;
  localparam int DCA_OUT_W       = 21;
  localparam int DCA_MIX_W       = 23;

  typedef logic [4:0]                  cycle_t;
  typedef logic [11:0]                 reg12_t;
  typedef logic signed [DCA_OUT_W-1:0] voice_t;
  typedef logic signed [DCA_MIX_W-1:0] mix_t;

  typedef struct packed {
    logic signed [12:0] w;
    logic [7:0]         env;
    logic [2:0]         slot;
    logic               mute;
  } dca_slot_t;

  // Centre the unsigned waveform around zero, optionally add the 6581 DC offset, saturate to 13 bits.
  function automatic logic signed [12:0] center_wave(input reg12_t wave,
                                                     input logic add_dc,
                                                     input logic signed [12:0] dc);
    logic signed [13:0] sum;
    sum = $signed({2'b00, wave}) - 14'sd2048;
    if (add_dc) begin
      sum = sum + $signed({dc[12], dc});
    end else begin
      sum = sum;
    end
    if (sum > 14'sd4095) begin
      return 13'sd4095;
    end else if (sum < -14'sd4096) begin
      return -13'sd4096;
    end else begin
      return sum[12:0];
    end
  endfunction

endpackage

// File: rtl/sid_dca_mul.sv
// Registered signed 13-bit x unsigned 8-bit multiplier with mute; the
// unregistered product is also exported so the mixer can accumulate on the same edge.
module sid_dca_mul
  import sid::*;
#(
  parameter int OUT_W = DCA_OUT_W
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    in_valid,
  input  logic signed [12:0]      w,
  input  logic [7:0]              env,
  input  logic                    mute,
  input  logic [2:0]              slot,
  output logic signed [OUT_W-1:0] prod,
  output logic signed [OUT_W-1:0] voice_out,
  output logic                    voice_valid,
  output logic [2:0]              voice_idx
);

  logic signed [OUT_W-1:0] prod_full;
  logic signed [OUT_W-1:0] voice_out_d, voice_out_q;
  logic                    voice_valid_d, voice_valid_q;
  logic [2:0]              voice_idx_d, voice_idx_q;

  // Product and next-state for the output register.
  always_comb begin
    prod_full     = OUT_W'(w) * OUT_W'($signed({1'b0, env}));
    prod          = mute ? '0 : prod_full;
    voice_valid_d = in_valid;
    if (in_valid) begin
      voice_out_d = prod;
      voice_idx_d = slot;
    end else begin
      voice_out_d = voice_out_q;
      voice_idx_d = voice_idx_q;
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      voice_out_q   <= '0;
      voice_valid_q <= 1'b0;
      voice_idx_q   <= 3'd0;
    end else begin
      voice_out_q   <= voice_out_d;
      voice_valid_q <= voice_valid_d;
      voice_idx_q   <= voice_idx_d;
    end
  end

  assign voice_out   = voice_out_q;
  assign voice_valid = voice_valid_q;
  assign voice_idx   = voice_idx_q;

endmodule

// File: rtl/sid_dca.sv
// SID digitally controlled amplifier: time-multiplexed over 2 chips x 3 voices,
// two-stage pipeline with per-chip 3-voice mix and OSC3/ENV3 readback latches.
module sid_dca
  import sid::*;
#(
  parameter int                 SLOT_BASE = DCA_SLOT_BASE,
  parameter logic signed [12:0] DC_6581   = -13'sd256,
  parameter int                 OUT_W     = DCA_OUT_W,
  parameter int                 MIX_W     = DCA_MIX_W
) (
  input  logic                    clk,
  input  logic                    res,
  input  cycle_t                  cycle,
  input  logic [11:0]             wave,
  input  logic [7:0]              env,
  input  logic [1:0]              model,
  input  logic [1:0]              voice3off,
  output logic signed [OUT_W-1:0] voice_out,
  output logic                    voice_valid,
  output logic [2:0]              voice_idx,
  output logic [1:0][MIX_W-1:0]   mix_out,
  output logic [1:0]              mix_valid,
  output logic [1:0][7:0]         osc3,
  output logic [1:0][7:0]         env3
);

  localparam cycle_t BASE_C = cycle_t'(SLOT_BASE);
  localparam cycle_t LAST_C = cycle_t'(SLOT_BASE + NUM_SLOTS - 1);

  logic       in_win;
  logic [2:0] slot;
  logic       chip;
  logic [1:0] voice;

  dca_slot_t  s1_d, s1_q;
  logic       s1_valid_d, s1_valid_q;
  logic [1:0][7:0] osc3_d, osc3_q, env3_d, env3_q;

  logic signed [OUT_W-1:0] prod;
  logic signed [MIX_W-1:0] p_ext;
  logic signed [MIX_W-1:0] acc_d, acc_q;
  logic [1:0][MIX_W-1:0]   mix_d, mix_q;
  logic [1:0]              mix_valid_d, mix_valid_q;
  // Per chip: bit 0 = voice 0 accumulated, bit 1 = voice 1 accumulated after it.
  logic [1:0][1:0]         seen_d, seen_q;
  logic                    c2;
  logic [1:0]              v2;

  // Slot decode for the current cycle.
  always_comb begin
    in_win = (cycle >= BASE_C) && (cycle <= LAST_C);
    slot   = 3'(cycle - BASE_C);
    chip   = (slot >= 3'd3);
    voice  = chip ? 2'(slot - 3'd3) : slot[1:0];
  end

  // Stage 1: centre the waveform and capture the readback latches.
  always_comb begin
    s1_valid_d = in_win;
    osc3_d     = osc3_q;
    env3_d     = env3_q;
    if (in_win) begin
      s1_d.w    = center_wave(wave, ~model[chip], DC_6581);
      s1_d.env  = env;
      s1_d.slot = slot;
      s1_d.mute = (voice == 2'd2) && voice3off[chip];
      if (voice == 2'd2) begin
        osc3_d[chip] = wave[11:4];
        env3_d[chip] = env;
      end else begin
        osc3_d[chip] = osc3_q[chip];
        env3_d[chip] = env3_q[chip];
      end
    end else begin
      s1_d = s1_q;
    end
  end

  sid_dca_mul #(
    .OUT_W (OUT_W)
  ) u_mul (
    .clk         (clk),
    .res         (res),
    .in_valid    (s1_valid_q),
    .w           (s1_q.w),
    .env         (s1_q.env),
    .mute        (s1_q.mute),
    .slot        (s1_q.slot),
    .prod        (prod),
    .voice_out   (voice_out),
    .voice_valid (voice_valid),
    .voice_idx   (voice_idx)
  );

  // Stage 2: per-chip accumulation; mix only published after a full voice 0..2 run.
  always_comb begin
    c2          = (s1_q.slot >= 3'd3);
    v2          = c2 ? 2'(s1_q.slot - 3'd3) : s1_q.slot[1:0];
    p_ext       = MIX_W'(prod);
    acc_d       = acc_q;
    mix_d       = mix_q;
    mix_valid_d = 2'b00;
    seen_d      = seen_q;
    if (s1_valid_q) begin
      case (v2)
        2'd0: begin
          acc_d      = p_ext;
          seen_d[c2] = 2'b01;
        end
        2'd1: begin
          acc_d      = acc_q + p_ext;
          seen_d[c2] = seen_q[c2][0] ? 2'b11 : 2'b00;
        end
        2'd2: begin
          acc_d = acc_q + p_ext;
          if (seen_q[c2] == 2'b11) begin
            mix_d[c2]       = acc_q + p_ext;
            mix_valid_d[c2] = 1'b1;
          end else begin
            mix_d[c2]       = mix_q[c2];
            mix_valid_d[c2] = 1'b0;
          end
        end
        default: begin
          acc_d = acc_q;
        end
      endcase
    end else begin
      acc_d = acc_q;
    end
  end

  // Pipeline, mixer and readback registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      osc3_q      <= '0;
      env3_q      <= '0;
      acc_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 2'b00;
      seen_q      <= '0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      osc3_q      <= osc3_d;
      env3_q      <= env3_d;
      acc_q       <= acc_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      seen_q      <= seen_d;
    end
  end

  assign mix_out   = mix_q;
  assign mix_valid = mix_valid_q;
  assign osc3      = osc3_q;
  assign env3      = env3_q;

endmodule

// File: tb/tb_sid_dca.sv
// Directed bench for sid_dca: frames of 16 cycles, outputs recorded per cycle
// and checked against hand-computed products, mixes and readback values.
module tb_sid_dca;
  import sid::*;

  logic               clk = 1'b0;
  logic               res = 1'b1;
  cycle_t             cycle;
  logic [11:0]        wave;
  logic [7:0]         env;
  logic [1:0]         model;
  logic [1:0]         voice3off;
  logic signed [20:0] voice_out;
  logic               voice_valid;
  logic [2:0]         voice_idx;
  logic [1:0][22:0]   mix_out;
  logic [1:0]         mix_valid;
  logic [1:0][7:0]    osc3;
  logic [1:0][7:0]    env3;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0]        wv [6];
  logic [7:0]         ev [6];
  logic signed [20:0] r_vo [16];
  logic               r_vv [16];
  logic [2:0]         r_vi [16];
  logic [1:0]         r_mv [16];
  logic [1:0][22:0]   r_mo [16];
  logic [1:0][7:0]    r_o3 [16];
  logic [1:0][7:0]    r_e3 [16];
  logic [104:0]       snap;

  sid_dca dut (
    .clk         (clk),
    .res         (res),
    .cycle       (cycle),
    .wave        (wave),
    .env         (env),
    .model       (model),
    .voice3off   (voice3off),
    .voice_out   (voice_out),
    .voice_valid (voice_valid),
    .voice_idx   (voice_idx),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .osc3        (osc3),
    .env3        (env3)
  );

  always #5 clk = ~clk;

  // One 16-cycle sample period; rst_at >= 0 pulses res from that cycle into the next.
  task automatic run_frame(input int rst_at);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (rst_at >= 0 && c == rst_at + 1) res = 1'b0;
      cycle = cycle_t'(c);
      if (c >= 6 && c < 12) begin
        wave = wv[c-6];
        env  = ev[c-6];
      end else begin
        wave = 12'($urandom);
        env  = 8'($urandom);
      end
      if (rst_at >= 0 && c == rst_at) begin
        #1 res = 1'b1;
        #1 snap = {voice_out, voice_valid, voice_idx, mix_out, mix_valid, osc3, env3};
      end
      @(negedge clk);
      r_vo[c] = voice_out;
      r_vv[c] = voice_valid;
      r_vi[c] = voice_idx;
      r_mv[c] = mix_valid;
      r_mo[c] = mix_out;
      r_o3[c] = osc3;
      r_e3[c] = env3;
    end
  endtask

  task automatic set_slots(input logic [11:0] w0, input logic [7:0] e0,
                           input logic [11:0] w1, input logic [7:0] e1,
                           input logic [11:0] w2, input logic [7:0] e2,
                           input logic [11:0] w3, input logic [7:0] e3,
                           input logic [11:0] w4, input logic [7:0] e4,
                           input logic [11:0] w5, input logic [7:0] e5);
    wv[0] = w0; ev[0] = e0; wv[1] = w1; ev[1] = e1; wv[2] = w2; ev[2] = e2;
    wv[3] = w3; ev[3] = e3; wv[4] = w4; ev[4] = e4; wv[5] = w5; ev[5] = e5;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (voice_out !== 21'sd0) begin n_err++; $display("FAIL rst_vo: got %0d want 0", voice_out); end
    n_cmp++; if (voice_valid !== 1'b0) begin n_err++; $display("FAIL rst_vv: got %0b want 0", voice_valid); end
    n_cmp++; if (voice_idx !== 3'd0) begin n_err++; $display("FAIL rst_vi: got %0d want 0", voice_idx); end
    n_cmp++; if (mix_out !== 46'd0) begin n_err++; $display("FAIL rst_mo: got %h want 0", mix_out); end
    n_cmp++; if (mix_valid !== 2'b00) begin n_err++; $display("FAIL rst_mv: got %b want 00", mix_valid); end
    n_cmp++; if (osc3 !== 16'h0000) begin n_err++; $display("FAIL rst_osc3: got %h want 0000", osc3); end
    n_cmp++; if (env3 !== 16'h0000) begin n_err++; $display("FAIL rst_env3: got %h want 0000", env3); end
    res = 1'b0;
  endtask

  task automatic test_full_scale();
    model = 2'b11; voice3off = 2'b00;
    set_slots(12'hFFF, 8'hFF, 12'h000, 8'hFF, 12'h000, 8'h00,
              12'h800, 8'h55, 12'h800, 8'h55, 12'h800, 8'h55);
    run_frame(-1);
    for (int c = 0; c < 8; c++) begin
      n_cmp++; if (r_vv[c] !== 1'b0) begin n_err++; $display("FAIL fs_idle_vv c%0d: got %0b want 0", c, r_vv[c]); end
    end
    n_cmp++; if (r_vo[8] !== 21'sd521985) begin n_err++; $display("FAIL fs_pos_vo: got %0d want 521985", r_vo[8]); end
    n_cmp++; if (r_vi[8] !== 3'd0) begin n_err++; $display("FAIL fs_pos_vi: got %0d want 0", r_vi[8]); end
    n_cmp++; if (r_vv[8] !== 1'b1) begin n_err++; $display("FAIL fs_pos_vv: got %0b want 1", r_vv[8]); end
    n_cmp++; if (r_vo[9] !== -21'sd522240) begin n_err++; $display("FAIL fs_neg_vo: got %0d want -522240", r_vo[9]); end
    n_cmp++; if (r_vi[9] !== 3'd1) begin n_err++; $display("FAIL fs_neg_vi: got %0d want 1", r_vi[9]); end
    n_cmp++; if (r_vo[10] !== 21'sd0) begin n_err++; $display("FAIL fs_zero_env_vo: got %0d want 0", r_vo[10]); end
    n_cmp++; if (r_mv[10] !== 2'b01) begin n_err++; $display("FAIL fs_mv10: got %b want 01", r_mv[10]); end
    n_cmp++; if ($signed(r_mo[10][0]) !== -23'sd255) begin n_err++; $display("FAIL fs_mix0: got %0d want -255", $signed(r_mo[10][0])); end
    n_cmp++; if (r_mv[11] !== 2'b00) begin n_err++; $display("FAIL fs_mv11: got %b want 00", r_mv[11]); end
    n_cmp++; if (r_mv[13] !== 2'b10) begin n_err++; $display("FAIL fs_mv13: got %b want 10", r_mv[13]); end
    n_cmp++; if ($signed(r_mo[13][1]) !== 23'sd0) begin n_err++; $display("FAIL fs_mix1: got %0d want 0", $signed(r_mo[13][1])); end
    n_cmp++; if (r_vv[14] !== 1'b0 || r_vv[15] !== 1'b0) begin n_err++; $display("FAIL fs_tail_vv: got %0b%0b want 00", r_vv[14], r_vv[15]); end
  endtask

  task automatic test_chip0_mix();
    model = 2'b11; voice3off = 2'b00;
    set_slots(12'hC00, 8'h80, 12'hC00, 8'h80, 12'hC00, 8'h80,
              12'h000, 8'h01, 12'h000, 8'h01, 12'h000, 8'h01);
    run_frame(-1);
    for (int c = 8; c < 11; c++) begin
      n_cmp++; if (r_vo[c] !== 21'sd131072) begin n_err++; $display("FAIL mix_vo c%0d: got %0d want 131072", c, r_vo[c]); end
    end
    n_cmp++; if (r_mv[9] !== 2'b00) begin n_err++; $display("FAIL mix_mv9: got %b want 00", r_mv[9]); end
    n_cmp++; if (r_mv[10] !== 2'b01) begin n_err++; $display("FAIL mix_mv10: got %b want 01", r_mv[10]); end
    n_cmp++; if ($signed(r_mo[10][0]) !== 23'sd393216) begin n_err++; $display("FAIL mix_mo0: got %0d want 393216", $signed(r_mo[10][0])); end
    n_cmp++; if ($signed(r_mo[15][0]) !== 23'sd393216) begin n_err++; $display("FAIL mix_hold: got %0d want 393216", $signed(r_mo[15][0])); end
    n_cmp++; if ($signed(r_mo[13][1]) !== -23'sd6144) begin n_err++; $display("FAIL mix_mo1: got %0d want -6144", $signed(r_mo[13][1])); end
  endtask

  task automatic test_6581();
    model = 2'b10; voice3off = 2'b00;
    set_slots(12'h800, 8'h10, 12'h000, 8'hFF, 12'hFFF, 8'h01,
              12'h800, 8'h10, 12'h000, 8'hFF, 12'h777, 8'h00);
    run_frame(-1);
    n_cmp++; if (r_vo[8] !== -21'sd4096) begin n_err++; $display("FAIL dc_mid: got %0d want -4096", r_vo[8]); end
    n_cmp++; if (r_vo[9] !== -21'sd587520) begin n_err++; $display("FAIL dc_min: got %0d want -587520", r_vo[9]); end
    n_cmp++; if (r_vo[10] !== 21'sd1791) begin n_err++; $display("FAIL dc_max: got %0d want 1791", r_vo[10]); end
    n_cmp++; if (r_vo[11] !== 21'sd0) begin n_err++; $display("FAIL dc_8580_mid: got %0d want 0", r_vo[11]); end
    n_cmp++; if (r_vo[12] !== -21'sd522240) begin n_err++; $display("FAIL dc_8580_min: got %0d want -522240", r_vo[12]); end
    n_cmp++; if ($signed(r_mo[10][0]) !== -23'sd589825) begin n_err++; $display("FAIL dc_mix0: got %0d want -589825", $signed(r_mo[10][0])); end
  endtask

  task automatic test_mute();
    model = 2'b11; voice3off = 2'b10;
    set_slots(12'h800, 8'h01, 12'h800, 8'h01, 12'h123, 8'h45,
              12'hC00, 8'h80, 12'hC00, 8'h80, 12'hABC, 8'h5A);
    run_frame(-1);
    n_cmp++; if (r_vo[10] !== -21'sd121233) begin n_err++; $display("FAIL mute_v2_chip0: got %0d want -121233", r_vo[10]); end
    n_cmp++; if (r_vo[13] !== 21'sd0) begin n_err++; $display("FAIL mute_vo: got %0d want 0", r_vo[13]); end
    n_cmp++; if (r_vi[13] !== 3'd5 || r_vv[13] !== 1'b1) begin n_err++; $display("FAIL mute_vi: got %0d/%0b want 5/1", r_vi[13], r_vv[13]); end
    n_cmp++; if ($signed(r_mo[13][1]) !== 23'sd262144) begin n_err++; $display("FAIL mute_mix1: got %0d want 262144", $signed(r_mo[13][1])); end
    n_cmp++; if (r_o3[11][1] !== 8'h77) begin n_err++; $display("FAIL mute_osc3_early: got %h want 77", r_o3[11][1]); end
    n_cmp++; if (r_o3[12][1] !== 8'hAB) begin n_err++; $display("FAIL mute_osc3: got %h want ab", r_o3[12][1]); end
    n_cmp++; if (r_e3[12][1] !== 8'h5A) begin n_err++; $display("FAIL mute_env3: got %h want 5a", r_e3[12][1]); end
    n_cmp++; if (r_o3[9][0] !== 8'h12 || r_e3[9][0] !== 8'h45) begin n_err++; $display("FAIL rb_chip0: got %h/%h want 12/45", r_o3[9][0], r_e3[9][0]); end
  endtask

  task automatic test_reset_mid();
    model = 2'b11; voice3off = 2'b00;
    set_slots(12'hC00, 8'h80, 12'hC00, 8'h80, 12'hC00, 8'h80,
              12'hC00, 8'h80, 12'hC00, 8'h80, 12'hC00, 8'h80);
    run_frame(9);
    n_cmp++; if (snap !== 105'd0) begin n_err++; $display("FAIL rm_snap: got %h want 0", snap); end
    for (int c = 0; c < 16; c++) begin
      n_cmp++; if (r_mv[c] !== 2'b00) begin n_err++; $display("FAIL rm_mv c%0d: got %b want 00", c, r_mv[c]); end
    end
    n_cmp++; if (r_vv[10] !== 1'b0 || r_vv[11] !== 1'b0) begin n_err++; $display("FAIL rm_vv_gap: got %0b%0b want 00", r_vv[10], r_vv[11]); end
    n_cmp++; if (r_vv[12] !== 1'b1 || r_vi[12] !== 3'd4 || r_vo[12] !== 21'sd131072) begin
      n_err++; $display("FAIL rm_resume: got %0b/%0d/%0d want 1/4/131072", r_vv[12], r_vi[12], r_vo[12]);
    end
    n_cmp++; if (r_vv[13] !== 1'b1 || r_vi[13] !== 3'd5) begin n_err++; $display("FAIL rm_slot5: got %0b/%0d want 1/5", r_vv[13], r_vi[13]); end
    run_frame(-1);
    n_cmp++; if (r_mv[10] !== 2'b01) begin n_err++; $display("FAIL rm_next_mv10: got %b want 01", r_mv[10]); end
    n_cmp++; if ($signed(r_mo[10][0]) !== 23'sd393216) begin n_err++; $display("FAIL rm_next_mix0: got %0d want 393216", $signed(r_mo[10][0])); end
    n_cmp++; if (r_mv[13] !== 2'b10) begin n_err++; $display("FAIL rm_next_mv13: got %b want 10", r_mv[13]); end
    n_cmp++; if ($signed(r_mo[13][1]) !== 23'sd393216) begin n_err++; $display("FAIL rm_next_mix1: got %0d want 393216", $signed(r_mo[13][1])); end
  endtask

  initial begin
    cycle     = cycle_t'(0);
    wave      = 12'h000;
    env       = 8'h00;
    model     = 2'b11;
    voice3off = 2'b00;
    test_reset();
    test_full_scale();
    test_chip0_mix();
    test_6581();
    test_mute();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sid_dca.md
Name: sid_dca

Overview:
- Digitally controlled amplifier stage directly downstream of the envelope generator.
- Time-multiplexed over 6 voice slots: 2 SID chips × 3 voices, in FPGA cycles 6..11.
- Per slot, multiplies the centred 12-bit waveform output by the 8-bit envelope value.
- Also produces a per-chip 3-voice sum and latches OSC3/ENV3 readback values for the register interface.

Parameters:
- SLOT_BASE, 6: first FPGA cycle carrying slot 0.
- DC_6581, -13'sd256: signed waveform zero-level offset added in 6581 mode.
- OUT_W, 21: signed voice product width.
- MIX_W, 23: signed per-chip mix width.

Ports:
- clk  in  1  system clock.
- res  in  1  reset; asynchronous, active-high.
- cycle  in  sid::cycle_t  FPGA cycle index within the sample period.
- wave  in  12  unsigned waveform output for slot (cycle - SLOT_BASE).
- env  in  8  envelope output for the same slot, aligned with wave.
- model  in  2  per chip: 0 = 6581, 1 = 8580.
- voice3off  in  2  per chip: mute voice 3 in the audio path.
- voice_out  out  OUT_W  signed product for voice_idx.
- voice_valid  out  1  voice_out qualifier.
- voice_idx  out  3  slot of voice_out (0..5).
- mix_out  out  2×MIX_W  per-chip signed sum of its 3 voices.
- mix_valid  out  2  one-cycle strobe per chip.
- osc3  out  2×8  per chip: wave[11:4] of voice 3.
- env3  out  2×8  per chip: env of voice 3.

Behaviour:
- Slot decoding:
  - Slot s = cycle - SLOT_BASE, valid for cycle in SLOT_BASE..SLOT_BASE+5.
  - chip = s / 3; voice = s % 3.
  - Inputs are ignored outside the slot window.
  - The cycle sequence spans at least 0..SLOT_BASE+7 per sample period.
- Stage 1 (edge at slot cycle):
  - w = {1'b0, wave} - 2048, as 13-bit signed.
  - If model[chip] = 0, w = w + DC_6581, saturated to -4096..4095.
  - Register w, env, s, and mute = (voice == 2 & voice3off[chip]).
- Stage 2 (next edge):
  - p = mute ? 0 : w × env (signed × unsigned, full 21-bit result, no truncation).
  - Register voice_out = p, voice_idx = s, voice_valid = 1.
- Latency and valid window:
  - voice_out is visible 2 cycles after the slot cycle, i.e. cycles 8..13 for SLOT_BASE = 6.
  - voice_valid = 0 in all other cycles.
- Accumulator (updated at the stage-2 edge):
  - voice 0: acc = p; voice 1 or 2: acc = acc + p.
  - At voice 2: mix_out[chip] = acc + p and mix_valid[chip] = 1 for one cycle (cycle 10 for chip 0, 13 for chip 1).
  - mix_out holds until the next update. MIX_W = 23 cannot overflow.
- Readback:
  - At the stage-1 edge of slot 2 / slot 5: osc3[chip] = wave[11:4], env3[chip] = env.
  - Readback is unaffected by voice3off and model.
- Per-chip seen flags:
  - Set at voice 0, cleared by res.
  - mix_valid[chip] is suppressed unless voices 0..2 of that chip were all accumulated since the last reset.
- Reset:
  - res asserted clears all registers asynchronously, whenever it occurs: voice_out = 0, voice_valid = 0, voice_idx = 0, mix_out = 0, mix_valid = 0, osc3 = 0, env3 = 0, seen flags = 0.
  - A reset mid-frame discards the partial sum.
  - Operation resumes at the first slot cycle after deassertion.
- Simultaneous events:
  - A voice 0 stage-2 update for chip 1 (cycle 11) and the stage-1 latch of other slots proceed independently.
  - There is no structural hazard; each pipeline register is single-slot.

Decomposition:
- Package sid:
  - dca_slot_t (w, env, slot, mute).
  - Constants NUM_SLOTS = 6, VOICES_PER_CHIP = 3, DCA_SLOT_BASE = 6.
  - reg12_t and the signed typedefs for voice_out and mix_out.
- Sub-module sid_dca_mul: one-stage registered signed 13 × unsigned 8 multiplier with a mute input, mapping to a DSP/MAC primitive.

Test Plan:
- Full-scale positive: model = 1, slot 0 wave = 0xFFF, env = 0xFF -> cycle 8: voice_out = 521985, voice_idx = 0, voice_valid = 1.
- Full-scale negative: model = 1, wave = 0x000, env = 0xFF -> voice_out = -522240; with env = 0x00 -> 0.
- Chip 0 mix: model = 1, slots 0..2 wave = 0xC00, env = 0x80 -> each voice_out = 131072; cycle 10: mix_out[0] = 393216 with a one-cycle mix_valid[0].
- 6581 offset: model[0] = 0, wave = 0x800, env = 0x10 -> voice_out = -4096; wave = 0x000, env = 0xFF -> -587520.
- Voice 3 muting: voice3off[1] = 1, slot 5 wave = 0xABC, env = 0x5A -> slot 5 voice_out = 0 at cycle 13; osc3[1] = 0xAB and env3[1] = 0x5A from cycle 12.
- Reset mid-frame: res pulsed during cycle 9 -> all outputs 0 immediately; after release, no mix_valid[0] until a complete slot 0..2 sequence, and mix_valid[1] fires at cycle 13 only after chip 1's voices 0..2 are all seen.
